// File: rtl/raster_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : raster_timer
// Purpose  : Video raster timing generator for the Vector-06C core. Runs on
//            clk24 and advances on ce12 pixel enables. Produces the column and
//            line counters, registered sync/blank/active flags, the scrolled
//            video row address, line/frame start strobes and the frame IRQ.
// Ports    : clk24, reset_n (async, active low), ce12 (pixel enable),
//            roll[7:0] (scroll register), irq_ack (IRQ acknowledge pulse)
//            -> hcount[9:0], vcount[8:0], hsync, vsync, active, blank,
//               vaddr[7:0], line_start, frame_start, irq
// Revision : 1.0 - initial release
// ============================================================================
module raster_timer #(
  parameter int unsigned H_TOTAL     = 768,
  parameter int unsigned H_ACT_START = 128,
  parameter int unsigned H_ACTIVE    = 512,
  parameter int unsigned HSYNC_START = 682,
  parameter int unsigned HSYNC_LEN   = 56,
  parameter int unsigned V_TOTAL     = 312,
  parameter int unsigned V_ACT_START = 40,
  parameter int unsigned V_ACTIVE    = 256,
  parameter int unsigned VSYNC_START = 300,
  parameter int unsigned VSYNC_LEN   = 4,
  parameter int unsigned INT_LINE    = 0
) (
  input  logic       clk24,
  input  logic       reset_n,
  input  logic       ce12,
  input  logic [7:0] roll,
  input  logic       irq_ack,
  output logic [9:0] hcount,
  output logic [8:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       blank,
  output logic [7:0] vaddr,
  output logic       line_start,
  output logic       frame_start,
  output logic       irq
);

  // Range bounds, upper bounds exclusive.
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT_LO  = 10'(H_ACT_START);
  localparam logic [9:0] H_ACT_HI  = 10'(H_ACT_START + H_ACTIVE);
  localparam logic [9:0] HS_LO     = 10'(HSYNC_START);
  localparam logic [9:0] HS_HI     = 10'(HSYNC_START + HSYNC_LEN);
  localparam logic [8:0] V_LAST    = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACT_LO  = 9'(V_ACT_START);
  localparam logic [8:0] V_ACT_HI  = 9'(V_ACT_START + V_ACTIVE);
  localparam logic [8:0] VS_LO     = 9'(VSYNC_START);
  localparam logic [8:0] VS_HI     = 9'(VSYNC_START + VSYNC_LEN);
  localparam logic [8:0] V_INT     = 9'(INT_LINE);
  localparam logic [7:0] V_ACT_LO8 = 8'(V_ACT_START);

  logic [7:0] roll_q;

  logic       h_wrap;
  logic [9:0] h_next;
  logic [8:0] v_next;
  logic       hs_next;
  logic       vs_next;
  logic       h_act_next;
  logic       v_act_next;
  logic       frame_next;
  logic [7:0] roll_d;
  logic [7:0] vaddr_next;
  logic       irq_set;

  // Flags are decoded from the value the counters are about to take, so that
  // once registered they line up with hcount/vcount in the same cycle.
  always_comb begin
    h_wrap     = (hcount == H_LAST);
    h_next     = h_wrap ? 10'd0 : hcount + 10'd1;
    v_next     = vcount;
    if (h_wrap) begin
      v_next = (vcount == V_LAST) ? 9'd0 : vcount + 9'd1;
    end
    hs_next    = (h_next >= HS_LO)    && (h_next < HS_HI);
    vs_next    = (v_next >= VS_LO)    && (v_next < VS_HI);
    h_act_next = (h_next >= H_ACT_LO) && (h_next < H_ACT_HI);
    v_act_next = (v_next >= V_ACT_LO) && (v_next < V_ACT_HI);
    frame_next = h_wrap && (v_next == 9'd0);
    // A freshly sampled scroll value applies to line 0 of the new frame too.
    roll_d     = frame_next ? roll : roll_q;
    // 8-bit arithmetic gives the mod-256 wrap of the scrolled row for free.
    vaddr_next = v_next[7:0] - V_ACT_LO8 + roll_d;
    irq_set    = ce12 && h_wrap && (v_next == V_INT);
  end

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      hcount      <= 10'd0;
      vcount      <= 9'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      active      <= 1'b0;
      blank       <= 1'b0;
      vaddr       <= 8'd0;
      roll_q      <= 8'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      irq         <= 1'b0;
    end else begin
      // Strobes self-clear on the next clk24 edge, so they stay one clk24
      // wide even when ce12 is held high continuously.
      line_start  <= ce12 && h_wrap;
      frame_start <= ce12 && frame_next;

      if (ce12) begin
        hcount <= h_next;
        vcount <= v_next;
        hsync  <= hs_next;
        vsync  <= vs_next;
        active <= h_act_next && v_act_next;
        blank  <= hs_next || vs_next;
        if (frame_next) begin
          roll_q <= roll;
        end
        // Row address latches at the start of an active line and then holds,
        // including through the inactive lines.
        if (h_wrap && v_act_next) begin
          vaddr <= vaddr_next;
        end
      end

      // Acknowledge is not gated by ce12; a coincident set wins.
      if (irq_set) begin
        irq <= 1'b1;
      end else if (irq_ack) begin
        irq <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_raster_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_raster_timer
// Purpose  : Directed self-checking bench for raster_timer. Instance u_d0 uses
//            the default 768x312 raster; u_d1 uses a scaled 32x80 raster so
//            whole frames fit in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raster_timer;

  // Scaled raster for u_d1.
  localparam int H    = 32;
  localparam int HA   = 4;
  localparam int HACT = 16;
  localparam int HS   = 24;
  localparam int HSL  = 3;
  localparam int V    = 80;
  localparam int VA   = 10;
  localparam int VACT = 64;
  localparam int VS   = 76;
  localparam int VSL  = 2;

  logic       clk24 = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce12 = 1'b0;
  logic       irq_ack = 1'b0;
  logic [7:0] roll = 8'd0;

  logic [9:0] a_hcount, b_hcount;
  logic [8:0] a_vcount, b_vcount;
  logic [7:0] a_vaddr, b_vaddr;
  logic a_hsync, a_vsync, a_active, a_blank, a_line_start, a_frame_start, a_irq;
  logic b_hsync, b_vsync, b_active, b_blank, b_line_start, b_frame_start, b_irq;

  int checks = 0;
  int failures = 0;
  int h_m = 0;
  int v_m = 0;

  always #5 clk24 = ~clk24;

  raster_timer u_d0 (
    .clk24(clk24), .reset_n(reset_n), .ce12(ce12), .roll(roll), .irq_ack(irq_ack),
    .hcount(a_hcount), .vcount(a_vcount), .hsync(a_hsync), .vsync(a_vsync),
    .active(a_active), .blank(a_blank), .vaddr(a_vaddr),
    .line_start(a_line_start), .frame_start(a_frame_start), .irq(a_irq)
  );

  raster_timer #(
    .H_TOTAL(H), .H_ACT_START(HA), .H_ACTIVE(HACT), .HSYNC_START(HS), .HSYNC_LEN(HSL),
    .V_TOTAL(V), .V_ACT_START(VA), .V_ACTIVE(VACT), .VSYNC_START(VS), .VSYNC_LEN(VSL),
    .INT_LINE(0)
  ) u_d1 (
    .clk24(clk24), .reset_n(reset_n), .ce12(ce12), .roll(roll), .irq_ack(irq_ack),
    .hcount(b_hcount), .vcount(b_vcount), .hsync(b_hsync), .vsync(b_vsync),
    .active(b_active), .blank(b_blank), .vaddr(b_vaddr),
    .line_start(b_line_start), .frame_start(b_frame_start), .irq(b_irq)
  );

  // Scaled-raster position tracker for u_d1.
  task automatic model_adv();
    if (h_m == H - 1) begin
      h_m = 0;
      v_m = (v_m == V - 1) ? 0 : v_m + 1;
    end else begin
      h_m = h_m + 1;
    end
  endtask

  // One idle clk24 edge, then one edge with ce12 high; returns 1 ns after it.
  task automatic step();
    @(posedge clk24); #1;
    ce12 = 1'b1;
    @(posedge clk24); #1;
    ce12 = 1'b0;
    model_adv();
  endtask

  task automatic run_to(input int tv, input int th);
    int n;
    n = 0;
    while (!(v_m == tv && h_m == th) && n < 2 * H * V) begin
      step();
      n++;
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    ce12 = 1'b0;
    irq_ack = 1'b0;
    repeat (3) @(posedge clk24);
    #1;
    reset_n = 1'b1;
    h_m = 0;
    v_m = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ce12 = 1'b1;
    repeat (3) @(posedge clk24);
    #1;
    ce12 = 1'b0;
    checks++;
    if ({a_hcount, a_vcount, a_vaddr} !== 27'd0) begin
      failures++;
      $display("FAIL reset_d0_counters: got h=%0d v=%0d vaddr=%0d expected 0", a_hcount, a_vcount, a_vaddr);
    end
    checks++;
    if ({a_hsync, a_vsync, a_active, a_blank, a_line_start, a_frame_start, a_irq} !== 7'd0) begin
      failures++;
      $display("FAIL reset_d0_flags: got %b expected 0000000",
               {a_hsync, a_vsync, a_active, a_blank, a_line_start, a_frame_start, a_irq});
    end
    checks++;
    if ({b_hcount, b_vcount, b_vaddr} !== 27'd0) begin
      failures++;
      $display("FAIL reset_d1_counters: got h=%0d v=%0d vaddr=%0d expected 0", b_hcount, b_vcount, b_vaddr);
    end
    checks++;
    if ({b_hsync, b_vsync, b_active, b_blank, b_line_start, b_frame_start, b_irq} !== 7'd0) begin
      failures++;
      $display("FAIL reset_d1_flags: got %b expected 0000000",
               {b_hsync, b_vsync, b_active, b_blank, b_line_start, b_frame_start, b_irq});
    end
  endtask

  // Default raster: first ce12 gives hcount=1 without a strobe, 768 pulses wrap
  // to line 1 with one line_start, hsync spans columns 682..737.
  task automatic test_first_line();
    int ls_n;
    int hs_first;
    int hs_last;
    apply_reset();
    step();
    checks++;
    if (a_hcount !== 10'd1 || a_line_start !== 1'b0 || a_frame_start !== 1'b0) begin
      failures++;
      $display("FAIL first_pulse: got h=%0d ls=%b fs=%b expected h=1 ls=0 fs=0",
               a_hcount, a_line_start, a_frame_start);
    end
    ls_n = 0;
    hs_first = -1;
    hs_last = -1;
    for (int i = 2; i <= 768; i++) begin
      step();
      if (a_line_start === 1'b1) ls_n++;
      if (a_hsync === 1'b1) begin
        if (hs_first < 0) hs_first = int'(a_hcount);
        hs_last = int'(a_hcount);
      end
    end
    checks++;
    if (a_hcount !== 10'd0 || a_vcount !== 9'd1) begin
      failures++;
      $display("FAIL line_wrap: got h=%0d v=%0d expected h=0 v=1", a_hcount, a_vcount);
    end
    checks++;
    if (ls_n !== 1) begin
      failures++;
      $display("FAIL line_start_count: got %0d expected 1", ls_n);
    end
    checks++;
    if (hs_first !== 682 || hs_last !== 737) begin
      failures++;
      $display("FAIL hsync_span: got %0d..%0d expected 682..737", hs_first, hs_last);
    end
  endtask

  // Scaled raster, two full frames checked pulse by pulse against the
  // position tracker and the flag definitions.
  task automatic test_frame();
    int e_cnt, e_hs, e_vs, e_act, e_blk, e_ls, e_fs, e_irq, e_va;
    int fs_n, fs_first, act_n, af_h, af_v, al_h, al_v;
    logic hs_e, vs_e, act_e, ls_e, fs_e, irq_e;
    logic [7:0] va_e;
    apply_reset();
    roll = 8'd0;
    {e_cnt, e_hs, e_vs, e_act, e_blk, e_ls, e_fs, e_irq, e_va} = '0;
    fs_n = 0; fs_first = 0; act_n = 0;
    af_h = -1; af_v = -1; al_h = -1; al_v = -1;
    irq_e = 1'b0;
    va_e = 8'd0;
    for (int p = 1; p <= 2 * H * V; p++) begin
      step();
      hs_e  = (h_m >= HS && h_m < HS + HSL);
      vs_e  = (v_m >= VS && v_m < VS + VSL);
      act_e = (h_m >= HA && h_m < HA + HACT) && (v_m >= VA && v_m < VA + VACT);
      ls_e  = (h_m == 0);
      fs_e  = ls_e && (v_m == 0);
      if (fs_e) irq_e = 1'b1;
      if (ls_e && v_m >= VA && v_m < VA + VACT) va_e = 8'(v_m - VA);
      if (b_hcount !== 10'(h_m) || b_vcount !== 9'(v_m)) e_cnt++;
      if (b_hsync !== hs_e) e_hs++;
      if (b_vsync !== vs_e) e_vs++;
      if (b_active !== act_e) e_act++;
      if (b_blank !== (hs_e | vs_e)) e_blk++;
      if (b_line_start !== ls_e) e_ls++;
      if (b_frame_start !== fs_e) e_fs++;
      if (b_irq !== irq_e) e_irq++;
      if (b_vaddr !== va_e) e_va++;
      if (b_frame_start === 1'b1) begin
        fs_n++;
        if (fs_first == 0) fs_first = p;
      end
      if (p > H * V && b_active === 1'b1) begin
        act_n++;
        if (af_h < 0) begin af_h = int'(b_hcount); af_v = int'(b_vcount); end
        al_h = int'(b_hcount); al_v = int'(b_vcount);
      end
    end
    checks++;
    if (e_cnt != 0) begin failures++; $display("FAIL frame_counters: got %0d bad pulses expected 0", e_cnt); end
    checks++;
    if (e_hs != 0) begin failures++; $display("FAIL frame_hsync: got %0d bad pulses expected 0", e_hs); end
    checks++;
    if (e_vs != 0) begin failures++; $display("FAIL frame_vsync: got %0d bad pulses expected 0", e_vs); end
    checks++;
    if (e_act != 0) begin failures++; $display("FAIL frame_active: got %0d bad pulses expected 0", e_act); end
    checks++;
    if (e_blk != 0) begin failures++; $display("FAIL frame_blank: got %0d bad pulses expected 0", e_blk); end
    checks++;
    if (e_ls != 0) begin failures++; $display("FAIL frame_line_start: got %0d bad pulses expected 0", e_ls); end
    checks++;
    if (e_fs != 0) begin failures++; $display("FAIL frame_frame_start: got %0d bad pulses expected 0", e_fs); end
    checks++;
    if (e_irq != 0) begin failures++; $display("FAIL frame_irq: got %0d bad pulses expected 0", e_irq); end
    checks++;
    if (e_va != 0) begin failures++; $display("FAIL frame_vaddr: got %0d bad pulses expected 0", e_va); end
    checks++;
    if (fs_n != 2 || fs_first != H * V) begin
      failures++;
      $display("FAIL frame_start_period: got count=%0d first=%0d expected count=2 first=%0d", fs_n, fs_first, H * V);
    end
    checks++;
    if (act_n != HACT * VACT) begin
      failures++;
      $display("FAIL active_total: got %0d expected %0d", act_n, HACT * VACT);
    end
    checks++;
    if (af_h != 4 || af_v != 10 || al_h != 19 || al_v != 73) begin
      failures++;
      $display("FAIL active_corners: got (%0d,%0d)..(%0d,%0d) expected (4,10)..(19,73)", af_h, af_v, al_h, al_v);
    end
  endtask

  task automatic test_strobe_width();
    apply_reset();
    run_to(0, H - 1);
    // ce12 held high over two consecutive edges.
    ce12 = 1'b1;
    @(posedge clk24); #1;
    checks++;
    if (b_line_start !== 1'b1 || b_hcount !== 10'd0 || b_vcount !== 9'd1) begin
      failures++;
      $display("FAIL strobe_cont_set: got ls=%b h=%0d v=%0d expected ls=1 h=0 v=1", b_line_start, b_hcount, b_vcount);
    end
    @(posedge clk24); #1;
    ce12 = 1'b0;
    checks++;
    if (b_line_start !== 1'b0 || b_hcount !== 10'd1) begin
      failures++;
      $display("FAIL strobe_cont_clear: got ls=%b h=%0d expected ls=0 h=1", b_line_start, b_hcount);
    end
    h_m = 1;
    v_m = 1;
    // Alternating ce12: the strobe still lasts a single clk24 cycle.
    run_to(2, 0);
    checks++;
    if (b_line_start !== 1'b1) begin
      failures++;
      $display("FAIL strobe_alt_set: got %b expected 1", b_line_start);
    end
    @(posedge clk24); #1;
    checks++;
    if (b_line_start !== 1'b0 || b_hcount !== 10'd0) begin
      failures++;
      $display("FAIL strobe_alt_clear: got ls=%b h=%0d expected ls=0 h=0", b_line_start, b_hcount);
    end
  endtask

  task automatic test_scroll();
    apply_reset();
    roll = 8'hF0;
    run_to(V - 1, H - 1);
    step();
    checks++;
    if (b_frame_start !== 1'b1) begin
      failures++;
      $display("FAIL scroll_frame_start: got %b expected 1", b_frame_start);
    end
    run_to(VA, 0);
    checks++;
    if (b_vaddr !== 8'hF0) begin
      failures++;
      $display("FAIL scroll_first_line: got %h expected f0", b_vaddr);
    end
    roll = 8'h33;
    run_to(VA + 16, 0);
    checks++;
    if (b_vaddr !== 8'h00) begin
      failures++;
      $display("FAIL scroll_wrap: got %h expected 00", b_vaddr);
    end
    run_to(VA + 16, 15);
    checks++;
    if (b_vaddr !== 8'h00) begin
      failures++;
      $display("FAIL scroll_mid_line: got %h expected 00", b_vaddr);
    end
    run_to(VA + VACT - 1, 0);
    checks++;
    if (b_vaddr !== 8'h2F) begin
      failures++;
      $display("FAIL scroll_last_line: got %h expected 2f", b_vaddr);
    end
    run_to(V - 1, 5);
    checks++;
    if (b_vaddr !== 8'h2F) begin
      failures++;
      $display("FAIL scroll_hold_inactive: got %h expected 2f", b_vaddr);
    end
    run_to(VA, 0);
    checks++;
    if (b_vaddr !== 8'h33) begin
      failures++;
      $display("FAIL scroll_next_frame: got %h expected 33", b_vaddr);
    end
  endtask

  task automatic test_irq();
    apply_reset();
    run_to(V - 1, H - 1);
    checks++;
    if (b_irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_before_set: got %b expected 0", b_irq);
    end
    step();
    checks++;
    if (b_irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_set: got %b expected 1", b_irq);
    end
    repeat (100) @(posedge clk24);
    #1;
    checks++;
    if (b_irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_level_hold: got %b expected 1", b_irq);
    end
    irq_ack = 1'b1;
    @(posedge clk24); #1;
    irq_ack = 1'b0;
    checks++;
    if (b_irq !== 1'b0 || b_hcount !== 10'd0) begin
      failures++;
      $display("FAIL irq_ack_clear: got irq=%b h=%0d expected irq=0 h=0", b_irq, b_hcount);
    end
    irq_ack = 1'b1;
    @(posedge clk24); #1;
    irq_ack = 1'b0;
    checks++;
    if (b_irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_ack_idle: got %b expected 0", b_irq);
    end
    // Acknowledge on the very edge that raises the request.
    run_to(V - 1, H - 1);
    @(posedge clk24); #1;
    ce12 = 1'b1;
    irq_ack = 1'b1;
    @(posedge clk24); #1;
    ce12 = 1'b0;
    irq_ack = 1'b0;
    model_adv();
    checks++;
    if (b_irq !== 1'b1 || b_frame_start !== 1'b1) begin
      failures++;
      $display("FAIL irq_set_wins: got irq=%b fs=%b expected irq=1 fs=1", b_irq, b_frame_start);
    end
    // Asynchronous reset drops the pending request without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (b_irq !== 1'b0 || b_frame_start !== 1'b0) begin
      failures++;
      $display("FAIL irq_async_reset: got irq=%b fs=%b expected 0 0", b_irq, b_frame_start);
    end
    reset_n = 1'b1;
  endtask

  // Default raster; column 700 is inside the hsync window there.
  task automatic test_reset_midline();
    apply_reset();
    repeat (700) step();
    checks++;
    if (a_hcount !== 10'd700 || a_hsync !== 1'b1 || a_blank !== 1'b1) begin
      failures++;
      $display("FAIL midline_pre: got h=%0d hs=%b blank=%b expected h=700 hs=1 blank=1", a_hcount, a_hsync, a_blank);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_hcount, a_vcount, a_vaddr} !== 27'd0 ||
        {a_hsync, a_vsync, a_active, a_blank, a_line_start, a_frame_start, a_irq} !== 7'd0) begin
      failures++;
      $display("FAIL midline_async_reset: got h=%0d hs=%b blank=%b expected all 0", a_hcount, a_hsync, a_blank);
    end
    @(posedge clk24); #1;
    reset_n = 1'b1;
    h_m = 0;
    v_m = 0;
    step();
    checks++;
    if (a_hcount !== 10'd1 || a_vcount !== 9'd0 || a_line_start !== 1'b0) begin
      failures++;
      $display("FAIL midline_resume: got h=%0d v=%0d ls=%b expected h=1 v=0 ls=0", a_hcount, a_vcount, a_line_start);
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_frame();
    test_strobe_width();
    test_scroll();
    test_irq();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
